pipeline_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV32I pipeline.
- Drives the load and flush/bubble enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Inputs: instruction/data memory handshakes, load-use hazards from ID/EX vs IF/ID, and the taken-branch/jump indication decoded from MEM/WB (pcmuxsel).
- Also gates wrong-path data-memory requests and keeps stall/flush performance counters.

---
 rtl/rv32i_types.sv | 11 +
 rtl/pipeline_ctrl_hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: pipeline controller state and register constants.
package rv32i_types;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } pipe_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: ID/EX load whose rd feeds the IF/ID instruction.
module hazard_detect
  import rv32i_types::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_uses_rs2,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = (idex_rd == ifid_rs1);
  assign rs2_hit = ifid_uses_rs2 & (idex_rd == ifid_rs2);

  assign hazard = idex_mem_read
                & (idex_rd != REG_X0)
                & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline with perf counters.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_taken,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  output logic             dmem_req_en,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_t      state_q, state_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic hazard;
  logic d_eff;
  logic i_ok;
  logic d_ok;
  logic ready;
  logic in_stall;

  hazard_detect u_hazard (
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .hazard        (hazard)
  );

  // Flags can only be set on the way into STALL
  assign in_stall = (state_q == STALL);
  assign d_eff    = dmem_req & ~br_taken;
  assign i_ok     = ~imem_req | imem_resp | (i_done_q & in_stall);
  assign d_ok     = ~d_eff | dmem_resp | (d_done_q & in_stall);
  assign ready    = i_ok & d_ok;

  assign dmem_req_en = rst_n & d_eff;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    if (!rst_n) begin
      load_pc      = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (!ready) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else begin
      unique case (1'b1)
        br_taken: begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
        end
        hazard & ~br_taken: begin
          load_pc     = 1'b0;
          load_if_id  = 1'b0;
          flush_id_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = RUN;
    i_done_d = 1'b0;
    d_done_d = 1'b0;
    stall_d  = stall_q;
    flush_d  = flush_q;
    if (!ready) begin
      state_d  = STALL;
      i_done_d = (i_done_q & in_stall) | (imem_req & imem_resp);
      d_done_d = (d_done_q & in_stall) | (d_eff & dmem_resp);
      if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end else if (br_taken) begin
      if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_resp, dmem_req, dmem_resp;
  logic        br_taken, idex_mem_read, ifid_uses_rs2;
  logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
  logic        dmem_req_en;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [31:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  logic [4:0] loads;
  logic [3:0] flushes;

  assign loads   = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
  assign flushes = {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_resp     (imem_resp),
    .dmem_req      (dmem_req),
    .dmem_resp     (dmem_resp),
    .br_taken      (br_taken),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .dmem_req_en   (dmem_req_en),
    .load_pc       (load_pc),
    .load_if_id    (load_if_id),
    .load_id_ex    (load_id_ex),
    .load_ex_mem   (load_ex_mem),
    .load_mem_wb   (load_mem_wb),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_ex_mem  (flush_ex_mem),
    .flush_mem_wb  (flush_mem_wb),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; imem_req = 0; imem_resp = 0; dmem_req = 1; dmem_resp = 0;
    br_taken = 0; idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0;
    ifid_rs2 = 0; ifid_uses_rs2 = 0;

    // reset
    cyc(); #1;
    chk("rst_loads", 32'(loads), 32'h0f);
    chk("rst_flush", 32'(flushes), 32'hf);
    chk("rst_den", 32'(dmem_req_en), 32'h0);
    cyc(); #1;
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    cyc(); rst_n = 1; dmem_req = 0; #1;
    chk("run_loads", 32'(loads), 32'h1f);
    chk("run_flush", 32'(flushes), 32'h0);

    // split imem/dmem responses
    for (int k = 0; k < 6; k++) begin
      cyc(); imem_req = 1; dmem_req = 1;
      imem_resp = (k == 2); dmem_resp = (k == 5); #1;
      chk($sformatf("split_loads%0d", k), 32'(loads),
          (k < 5) ? 32'h00 : 32'h1f);
      chk($sformatf("split_den%0d", k), 32'(dmem_req_en), 32'h1);
    end
    cyc(); imem_resp = 0; dmem_resp = 0; dmem_req = 0; #1;
    chk("split_scnt", stall_cnt, 5);
    chk("idone_clr", 32'(loads), 32'h00);
    cyc(); imem_req = 0; #1;
    chk("idone_run", 32'(loads), 32'h1f);
    chk("scnt6", stall_cnt, 6);

    // load-use hazards
    cyc(); idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; #1;
    chk("lu_rs1_loads", 32'(loads), 32'h07);
    chk("lu_rs1_flush", 32'(flushes), 32'h4);
    cyc(); ifid_rs1 = 0; ifid_rs2 = 5; ifid_uses_rs2 = 0; #1;
    chk("lu_rs2_unused", 32'(loads), 32'h1f);
    chk("lu_rs2_unused_fl", 32'(flushes), 32'h0);
    cyc(); ifid_uses_rs2 = 1; #1;
    chk("lu_rs2_used", 32'(loads), 32'h07);
    cyc(); idex_rd = 0; ifid_rs2 = 0; ifid_rs1 = 0; #1;
    chk("lu_x0", 32'(loads), 32'h1f);
    chk("lu_scnt", stall_cnt, 6);

    // branch flush over hazard and dmem request
    cyc(); br_taken = 1; idex_rd = 5; ifid_rs1 = 5; dmem_req = 1; #1;
    chk("br_den", 32'(dmem_req_en), 32'h0);
    chk("br_loads", 32'(loads), 32'h1f);
    chk("br_flush", 32'(flushes), 32'hf);
    cyc(); br_taken = 0; dmem_req = 0; idex_mem_read = 0;
    idex_rd = 0; ifid_rs1 = 0; ifid_uses_rs2 = 0; #1;
    chk("br_fcnt", flush_cnt, 1);

    // branch while fetch is stalled
    for (int k = 0; k < 4; k++) begin
      cyc(); imem_req = 1; br_taken = 1; dmem_req = 1;
      imem_resp = (k == 3); #1;
      chk($sformatf("bri_loads%0d", k), 32'(loads),
          (k < 3) ? 32'h00 : 32'h1f);
      chk($sformatf("bri_flush%0d", k), 32'(flushes),
          (k < 3) ? 32'h0 : 32'hf);
      chk($sformatf("bri_den%0d", k), 32'(dmem_req_en), 32'h0);
    end
    cyc(); imem_req = 0; imem_resp = 0; br_taken = 0; dmem_req = 0; #1;
    chk("bri_scnt", stall_cnt, 9);
    chk("bri_fcnt", flush_cnt, 2);

    // reset during a dmem stall, response in flight dropped
    cyc(); dmem_req = 1; #1;
    chk("mr_stall0", 32'(loads), 32'h00);
    cyc(); #1;
    chk("mr_stall1", 32'(loads), 32'h00);
    cyc(); rst_n = 0; dmem_resp = 1; #1;
    chk("mr_rst_loads", 32'(loads), 32'h0f);
    cyc(); rst_n = 1; dmem_resp = 0; #1;
    chk("mr_scnt", stall_cnt, 0);
    chk("mr_fcnt", flush_cnt, 0);
    chk("mr_ddone", 32'(loads), 32'h00);
    cyc(); dmem_resp = 1; #1;
    chk("mr_resume", 32'(loads), 32'h1f);
    cyc(); dmem_resp = 0; dmem_req = 0; #1;
    chk("mr_scnt1", stall_cnt, 1);

    // response without a matching request is ignored
    cyc(); imem_req = 1; dmem_resp = 1; #1;
    chk("orph_stall", 32'(loads), 32'h00);
    cyc(); dmem_req = 1; dmem_resp = 0; imem_resp = 1; #1;
    chk("orph_nodone", 32'(loads), 32'h00);
    cyc(); imem_resp = 0; dmem_resp = 1; #1;
    chk("orph_idone", 32'(loads), 32'h1f);
    cyc(); imem_req = 0; dmem_req = 0; dmem_resp = 0; #1;
    chk("orph_scnt", stall_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
